i2c_fifo: RTL and testbench
===========================

# i2c_fifo

Synchronous first-word-fall-through FIFO used twice in the I2C master: as the TX FIFO between the APB slave and the I2C core, and as the RX FIFO between the I2C core and the APB slave. The write side accepts one word per cycle on a level enable. The read side presents the head word combinationally, so the APB slave can drive it onto prdata in the same access cycle that pops it. Status flags feed the APB interrupt lines (int_tx / int_rx) and the core's "data available" check.

## Interface
Parameters:
- DWIDTH, 32, data word width (32 for TX, 16 for RX instance)
- AWIDTH, 4, address width; depth = 2**AWIDTH entries

Ports:
- pclk, input, 1, single clock; all state changes on rising edge
- presetn, input, 1, asynchronous active-low reset
- wr_en, input, 1, write request; sampled every rising edge
- data_in, input, DWIDTH, write data, captured with wr_en
- rd_en, input, 1, read (pop) request; sampled every rising edge
- data_out, output, DWIDTH, head-of-FIFO word (FWFT, combinational from storage)
- empty, output, 1, no valid entries
- full, output, 1, 2**AWIDTH valid entries
- count, output, AWIDTH+1, number of valid entries, 0..2**AWIDTH
- overflow, output, 1, one-cycle pulse: write rejected because full
- underflow, output, 1, one-cycle pulse: read rejected because empty

## Operation
- Storage: 2**AWIDTH x DWIDTH register array. No reset on the array.
- wr_ptr, rd_ptr: AWIDTH+1 bits each; the extra MSB is the wrap bit.
- Pointer state:
  - empty = (wr_ptr == rd_ptr).
  - full = (AWIDTH LSBs equal) and (MSBs differ).
  - count = wr_ptr - rd_ptr, modulo 2**(AWIDTH+1).
- Write accepted iff wr_en && !full.
  - mem[wr_ptr[AWIDTH-1:0]] <= data_in.
  - wr_ptr increments by 1 and wraps naturally through the extra bit.
- Read accepted iff rd_en && !empty.
  - rd_ptr increments by 1.
  - data_out always equals mem[rd_ptr[AWIDTH-1:0]]. It is undefined-but-stable (last storage content) when empty.
- Acceptance depends only on current flags, never on the other port:
  - Full, with wr_en and rd_en together: read accepted, write rejected; overflow pulses. count goes from 2**AWIDTH to 2**AWIDTH-1.
  - Empty, with wr_en and rd_en together: write accepted, read rejected; underflow pulses. count goes from 0 to 1.
  - Neither full nor empty, with both requests: both accepted; count unchanged; pointers both advance.
- overflow <= wr_en && full; underflow <= rd_en && empty. Both are registered, so each is high for exactly the cycle after the offending edge.
- Reset (async assert, any time including mid-transfer):
  - wr_ptr = rd_ptr = 0, giving empty=1, full=0, count=0.
  - overflow=0, underflow=0.
  - Contents are discarded logically. Release is synchronous to pclk through the normal flop path; the first edge after release may already accept a write.

## Timing
- Write-to-read latency: a word written at edge N is visible on data_out and counted after edge N. It can be popped at edge N+1.
- Flags and count update on the same edge as the pointer change. No combinational path runs from wr_en/rd_en to empty, full or count.
- data_out changes only after the edge at which rd_ptr moves or a write lands in the head slot. It never changes combinationally with rd_en.
- Sustained throughput: one write and one read per cycle with no bubbles.
- Reset values: empty=1, full=0, count=0, overflow=0, underflow=0, data_out=mem[0] (undefined).

## Test plan
- Reset then fill (AWIDTH=4, DWIDTH=32):
  - After reset: empty=1, count=0.
  - Write 0x00000001..0x00000010 on 16 consecutive edges.
  - After the 16th edge: full=1, count=16, data_out=0x00000001.
- Overflow while full: one more write of 0xDEADBEEF.
  - overflow=1 for one cycle; count stays 16.
  - A later drain never returns 0xDEADBEEF.
- Drain and wrap:
  - 16 reads return 0x1..0x10 in order. Final state: empty=1, count=0.
  - Then 20 writes interleaved with reads take the pointers across the wrap boundary; data order is preserved and full never asserts falsely.
- Simultaneous access at the boundaries:
  - At count=16, rd_en+wr_en gives count=15 and overflow=1.
  - At count=0, rd_en+wr_en gives count=1, underflow=1, and data_out = the written word.
  - At count=5, both requested gives count=5 and the head advances.
- Underflow: rd_en while empty gives underflow=1 for one cycle, and rd_ptr stays unchanged.
- Async reset mid-operation: with count=7, assert presetn low between edges.
  - empty=1, full=0 and count=0 immediately, without waiting for a clock edge.
  - After release, writing 0x00000AAA gives data_out=0x00000AAA and count=1.

Source files
------------

// File: rtl/i2c_fifo_if.sv
// Handshake bundle between a FIFO user and i2c_fifo: level write/pop enables in, head word and status out.
// The master modport is the FIFO user (APB slave or I2C core); the slave modport is the FIFO itself.
interface i2c_fifo_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
);
   logic              wr_en;
   logic [DWIDTH-1:0] data_in;
   logic              rd_en;
   logic [DWIDTH-1:0] data_out;
   logic              empty;
   logic              full;
   logic [AWIDTH:0]   count;
   logic              overflow;
   logic              underflow;

   modport master (
      output wr_en, data_in, rd_en,
      input  data_out, empty, full, count, overflow, underflow
   );

   modport slave (
      input  wr_en, data_in, rd_en,
      output data_out, empty, full, count, overflow, underflow
   );
endinterface

// File: rtl/i2c_fifo.sv
// First-word-fall-through FIFO: a write is visible on data_out one edge later, a read pops with zero latency.
// No stall signals: a write while full or a pop while empty is dropped and flagged by a one-cycle pulse.
module i2c_fifo #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
) (
   input  logic         pclk,
   input  logic         presetn,
   i2c_fifo_if.slave    bus
);
   localparam int              DEPTH   = 1 << AWIDTH;
   localparam logic [AWIDTH:0] PTR_ONE = 1;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] mem_d [DEPTH];
   logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              is_empty, is_full;
   logic              wr_accept, rd_accept;

   // Extra pointer MSB distinguishes a full ring from an empty one.
   assign is_empty = (wr_ptr_q == rd_ptr_q);
   assign is_full  = (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]) &&
                     (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]);

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wr_accept   = bus.wr_en && !is_full;
      rd_accept   = bus.rd_en && !is_empty;
      overflow_d  = bus.wr_en && is_full;
      underflow_d = bus.rd_en && is_empty;

      if (wr_accept) begin
         mem_d[wr_ptr_q[AWIDTH-1:0]] = bus.data_in;
         wr_ptr_d                    = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is deliberately left out of reset; emptiness is tracked by the pointers alone.
   always_ff @(posedge pclk) begin
      mem_q <= mem_d;
   end

   assign bus.data_out  = mem_q[rd_ptr_q[AWIDTH-1:0]];
   assign bus.empty     = is_empty;
   assign bus.full      = is_full;
   assign bus.count     = wr_ptr_q - rd_ptr_q;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_i2c_fifo.sv
// Bench for i2c_fifo (DWIDTH=32, AWIDTH=4): queue scoreboard for data order and flags, plus a vector table for boundary cases.
module tb_i2c_fifo;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] din;
      int          exp_count;
      logic        exp_ovf;
      logic        exp_unf;
      logic        chk_dout;
      logic [31:0] exp_dout;
   } vec_t;

   logic pclk;
   logic presetn;
   int   checks;
   int   errors;
   logic [31:0] sb[$];
   vec_t        vecs[$];

   i2c_fifo_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   i2c_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Called right after a falling edge; drives one request, then checks state after the rising edge.
   task automatic cycle(input logic wr, input logic rd, input logic [31:0] din);
      logic empty_m, full_m;
      empty_m     = (sb.size() == 0);
      full_m      = (sb.size() == DEPTH);
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.data_in = din;
      if (rd && !empty_m) chk("head_data", bus.data_out, sb[0]);
      @(posedge pclk);
      if (rd && !empty_m) void'(sb.pop_front());
      if (wr && !full_m) sb.push_back(din);
      @(negedge pclk);
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      chk("count", 32'(bus.count), 32'(sb.size()));
      chk("empty", 32'(bus.empty), 32'(sb.size() == 0));
      chk("full", 32'(bus.full), 32'(sb.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(wr && full_m));
      chk("underflow", 32'(bus.underflow), 32'(rd && empty_m));
   endtask

   task automatic add_vec(input logic wr, input logic rd, input logic [31:0] din, input int cnt,
                          input logic ovf, input logic unf, input logic cd, input logic [31:0] dout);
      vec_t v;
      v.wr = wr; v.rd = rd; v.din = din; v.exp_count = cnt;
      v.exp_ovf = ovf; v.exp_unf = unf; v.chk_dout = cd; v.exp_dout = dout;
      vecs.push_back(v);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      presetn     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;

      // Boundary vectors, starting from an empty FIFO.
      add_vec(1, 1, 32'h11, 1, 0, 1, 1, 32'h11);
      add_vec(1, 0, 32'h22, 2, 0, 0, 1, 32'h11);
      add_vec(1, 0, 32'h33, 3, 0, 0, 0, 0);
      add_vec(1, 0, 32'h44, 4, 0, 0, 0, 0);
      add_vec(1, 0, 32'h55, 5, 0, 0, 1, 32'h11);
      add_vec(1, 1, 32'h66, 5, 0, 0, 1, 32'h22);
      for (int i = 0; i < 11; i++) add_vec(1, 0, 32'h70 + i, 6 + i, 0, 0, 1, 32'h22);
      add_vec(1, 1, 32'h0BAD, 15, 1, 0, 1, 32'h33);
      add_vec(0, 0, 32'h0, 15, 0, 0, 1, 32'h33);
      for (int i = 0; i < 15; i++) add_vec(0, 1, 32'h0, 14 - i, 0, 0, 0, 0);
      add_vec(0, 1, 32'h0, 0, 0, 1, 0, 0);
      add_vec(0, 0, 32'h0, 0, 0, 0, 0, 0);
      add_vec(1, 0, 32'h77, 1, 0, 0, 1, 32'h77);
      add_vec(0, 1, 32'h0, 0, 0, 0, 0, 0);

      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_underflow", 32'(bus.underflow), 32'd0);

      for (int i = 1; i <= 16; i++) cycle(1, 0, 32'(i));
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_count", 32'(bus.count), 32'd16);
      chk("fill_head", bus.data_out, 32'h1);

      cycle(1, 0, 32'hDEADBEEF);
      chk("ovf_pulse", 32'(bus.overflow), 32'd1);
      cycle(0, 0, 32'h0);

      for (int i = 0; i < 16; i++) cycle(0, 1, 32'h0);
      chk("drain_empty", 32'(bus.empty), 32'd1);

      for (int i = 0; i < 20; i++) cycle(1, (i >= 2), 32'h100 + 32'(i));
      while (sb.size() != 0) cycle(0, 1, 32'h0);

      foreach (vecs[i]) begin
         cycle(vecs[i].wr, vecs[i].rd, vecs[i].din);
         chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
         chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
         chk($sformatf("vec%0d_unf", i), 32'(bus.underflow), 32'(vecs[i].exp_unf));
         if (vecs[i].chk_dout) chk($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_dout);
      end

      for (int i = 0; i < 7; i++) cycle(1, 0, 32'h200 + 32'(i));
      chk("pre_rst_count", 32'(bus.count), 32'd7);
      #2;
      presetn = 1'b0;
      #1;
      chk("arst_empty", 32'(bus.empty), 32'd1);
      chk("arst_full", 32'(bus.full), 32'd0);
      chk("arst_count", 32'(bus.count), 32'd0);
      sb.delete();
      @(negedge pclk);
      presetn = 1'b1;
      cycle(1, 0, 32'h00000AAA);
      chk("post_rst_head", bus.data_out, 32'h00000AAA);
      chk("post_rst_count", 32'(bus.count), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
